// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: ROM address/data, decode valid/ready output and branch redirect.
// The controller uses the master modport; the ROM/decode/branch side uses slave.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc,
    input  rom_instr, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc,
    output rom_instr, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational ROM, registers
// the word for decode over valid/ready, handles redirect/flush and HALT.
//
//   state | meaning
//   IDLE  | waiting for start; redirect only reloads the PC
//   RUN   | fetching one word per cycle whenever the output slot is free
//   HALT  | HALT word seen; drain the pending word, wait for redirect
module instr_fetch_ctrl #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR  = 32'hFFFF_FFFF,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  instr_fetch_ctrl_if.master     bus,
  output logic                   busy,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] out_pc_q;
  logic                  accept;
  logic                  load;
  logic                  is_halt;

  assign accept  = valid_q && bus.out_ready;
  // Redirect outranks a load, so a fetch never lands in the same cycle as a flush.
  assign load    = (state == RUN) && !bus.redirect_valid && (!valid_q || bus.out_ready);
  assign is_halt = (bus.rom_instr == HALT_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      out_pc_q    <= '0;
      instr_count <= '0;
    end else begin
      if (accept && (instr_count != COUNT_MAX))
        instr_count <= instr_count + 1'b1;

      case (state)
        IDLE: begin
          if (bus.redirect_valid)
            pc <= bus.redirect_pc;
          if (start)
            state <= RUN;
        end
        RUN, HALT: begin
          if (bus.redirect_valid) begin
            pc      <= bus.redirect_pc;
            valid_q <= 1'b0;
            state   <= RUN;
          end else if (state == RUN) begin
            if (load) begin
              instr_q  <= bus.rom_instr;
              out_pc_q <= pc;
              valid_q  <= 1'b1;
              if (is_halt)
                state <= HALT;
              else
                pc <= pc + 1'b1;
            end
          end else if (accept) begin
            valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = pc;
  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_pc    = out_pc_q;
  assign busy          = (state == RUN);
  assign halted        = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: cycle table for the basic run, scoreboard of
// expected {instr, pc} words, and hand-written stall/redirect/wrap/reset/saturation sequences.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] W_A = 32'hA000_0001;
  localparam logic [31:0] W_B = 32'hB000_0002;
  localparam logic [31:0] W_C = 32'hC000_0003;
  localparam logic [31:0] W_D = 32'hD000_0040;
  localparam logic [31:0] W_E = 32'hE000_00FF;

  logic clk;
  logic rst_n;
  logic start, start2;
  logic busy, halted, busy2, halted2;
  logic [15:0] instr_count;
  logic [1:0]  instr_count2;

  logic [31:0] rom [256];

  instr_fetch_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus1 ();
  instr_fetch_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus2 ();

  instr_fetch_ctrl #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
    .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  instr_fetch_ctrl #(.COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
    .busy(busy2), .halted(halted2), .instr_count(instr_count2)
  );

  assign bus1.rom_instr = rom[bus1.rom_addr];
  assign bus2.rom_instr = rom[bus2.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        start;
    logic        ready;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [7:0]  e_addr;
    logic        e_busy;
    logic        e_halted;
    logic [15:0] e_count;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference fetch stream from a start address up to and including the HALT word.
  task automatic push_stream(input logic [7:0] from);
    logic [7:0] p;
    p = from;
    for (int i = 0; i < 256; i++) begin
      sb.push_back('{instr: rom[p], pc: p});
      if (rom[p] == HALT_W) break;
      p = p + 8'd1;
    end
  endtask

  task automatic cycle();
    exp_t e;
    if (bus1.out_valid && bus1.out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got pc %0h instr %0h, expected no transfer", bus1.out_pc, bus1.out_instr);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", {32'd0, bus1.out_instr}, {32'd0, e.instr});
        chk("sb_pc", {56'd0, bus1.out_pc}, {56'd0, e.pc});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; start2 = 1'b0;
    bus1.out_ready = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 8'h00;
    bus2.out_ready = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 8'h00;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_halt(input string name);
    for (int i = 0; i < 30 && !(halted && !bus1.out_valid); i++) cycle();
    chk(name, {63'd0, halted && !bus1.out_valid}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_1000 + 32'(i);
    rom[0] = W_A; rom[1] = W_B; rom[2] = W_C; rom[3] = HALT_W;
    rom[8'h40] = W_D; rom[8'h41] = HALT_W; rom[8'hFF] = W_E;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 1'b1, 1'b0, 16'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h02, 8'h03, 1'b1, 1'b0, 16'd2};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h03, 8'h03, 1'b0, 1'b1, 16'd3};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b1, 16'd4};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b1, 16'd4};

    // Reset values
    start = 1'b0; start2 = 1'b0;
    bus1.out_ready = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 8'h00;
    bus2.out_ready = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 8'h00;
    rst_n = 1'b0;
    #2;
    chk("rst_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("rst_addr", {56'd0, bus1.rom_addr}, 64'd0);
    chk("rst_busy_halted", {62'd0, busy, halted}, 64'd0);
    chk("rst_count", {48'd0, instr_count}, 64'd0);
    chk("rst_count2", {62'd0, instr_count2}, 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: table-driven run A,B,C,HALT with ready high
    push_stream(8'h00);
    for (int i = 0; i < 7; i++) begin
      start = vecs[i].start;
      bus1.out_ready = vecs[i].ready;
      cycle();
      chk($sformatf("t1_valid[%0d]", i), {63'd0, bus1.out_valid}, {63'd0, vecs[i].e_valid});
      if (vecs[i].e_valid)
        chk($sformatf("t1_pc[%0d]", i), {56'd0, bus1.out_pc}, {56'd0, vecs[i].e_pc});
      chk($sformatf("t1_addr[%0d]", i), {56'd0, bus1.rom_addr}, {56'd0, vecs[i].e_addr});
      chk($sformatf("t1_state[%0d]", i), {62'd0, busy, halted}, {62'd0, vecs[i].e_busy, vecs[i].e_halted});
      chk($sformatf("t1_count[%0d]", i), {48'd0, instr_count}, {48'd0, vecs[i].e_count});
    end
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: stall for three cycles after the first valid word
    do_reset();
    push_stream(8'h00);
    start = 1'b1; cycle();
    start = 1'b0; cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_hold_valid", {63'd0, bus1.out_valid}, 64'd1);
      chk("t2_hold_instr", {32'd0, bus1.out_instr}, {32'd0, W_A});
      chk("t2_hold_pc", {56'd0, bus1.out_pc}, 64'd0);
      chk("t2_hold_addr", {56'd0, bus1.rom_addr}, 64'd1);
      chk("t2_hold_count", {48'd0, instr_count}, 64'd0);
    end
    bus1.out_ready = 1'b1;
    run_to_halt("t2_halt_timeout");
    chk("t2_count", {48'd0, instr_count}, 64'd4);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: redirect while a word is stalled, then redirect with same-cycle accept
    do_reset();
    start = 1'b1; cycle();
    start = 1'b0; cycle();
    bus1.redirect_valid = 1'b1; bus1.redirect_pc = 8'h40;
    cycle();
    bus1.redirect_valid = 1'b0;
    chk("t3_flush_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("t3_flush_addr", {56'd0, bus1.rom_addr}, 64'h40);
    chk("t3_flush_busy", {63'd0, busy}, 64'd1);
    push_stream(8'h40);
    cycle();
    chk("t3_d_valid", {63'd0, bus1.out_valid}, 64'd1);
    chk("t3_d_pc", {56'd0, bus1.out_pc}, 64'h40);
    chk("t3_d_instr", {32'd0, bus1.out_instr}, {32'd0, W_D});
    chk("t3_d_count", {48'd0, instr_count}, 64'd0);
    bus1.redirect_valid = 1'b1; bus1.out_ready = 1'b1;
    cycle();
    bus1.redirect_valid = 1'b0;
    chk("t3_acc_flush_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("t3_acc_count", {48'd0, instr_count}, 64'd1);
    sb.delete();
    push_stream(8'h40);
    run_to_halt("t3_halt_timeout");
    chk("t3_count", {48'd0, instr_count}, 64'd3);
    chk("t3_halt_addr", {56'd0, bus1.rom_addr}, 64'h41);
    bus1.redirect_valid = 1'b1; bus1.redirect_pc = 8'h00;
    cycle();
    bus1.redirect_valid = 1'b0;
    chk("t3_leave_halt", {62'd0, busy, halted}, 64'b10);

    // 4: IDLE redirect to 0xFF, then PC wraps to 0x00
    do_reset();
    bus1.out_ready = 1'b1;
    bus1.redirect_valid = 1'b1; bus1.redirect_pc = 8'hFF;
    cycle();
    bus1.redirect_valid = 1'b0;
    chk("t4_idle_addr", {56'd0, bus1.rom_addr}, 64'hFF);
    chk("t4_idle_state", {62'd0, busy, halted}, 64'd0);
    push_stream(8'hFF);
    start = 1'b1; cycle();
    start = 1'b0; cycle();
    chk("t4_e_pc", {56'd0, bus1.out_pc}, 64'hFF);
    chk("t4_wrap_addr", {56'd0, bus1.rom_addr}, 64'h00);
    run_to_halt("t4_halt_timeout");
    chk("t4_count", {48'd0, instr_count}, 64'd5);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // 5: asynchronous reset in the middle of a stream
    do_reset();
    bus1.out_ready = 1'b1;
    push_stream(8'h00);
    start = 1'b1; cycle();
    start = 1'b0; cycle(); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("t5_instr", {32'd0, bus1.out_instr}, 64'd0);
    chk("t5_pc", {56'd0, bus1.out_pc}, 64'd0);
    chk("t5_addr", {56'd0, bus1.rom_addr}, 64'd0);
    chk("t5_count", {48'd0, instr_count}, 64'd0);
    chk("t5_state", {62'd0, busy, halted}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_idle_busy", {63'd0, busy}, 64'd0);
    chk("t5_idle_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("t5_idle_addr", {56'd0, bus1.rom_addr}, 64'd0);

    // 6: 2-bit counter saturates at 3
    do_reset();
    begin
      int n2;
      n2 = 0;
      bus2.out_ready = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
        if (pass == 0) begin
          start2 = 1'b1; cycle(); start2 = 1'b0;
        end else begin
          bus2.redirect_valid = 1'b1; bus2.redirect_pc = 8'h00;
          cycle();
          bus2.redirect_valid = 1'b0;
        end
        for (int i = 0; i < 30 && !(halted2 && !bus2.out_valid); i++) begin
          if (bus2.out_valid && bus2.out_ready) n2++;
          cycle();
          chk("t6_count_step", {62'd0, instr_count2}, (n2 > 3) ? 64'd3 : 64'(n2));
        end
        chk("t6_halt_timeout", {63'd0, halted2 && !bus2.out_valid}, 64'd1);
      end
      chk("t6_transfers", 64'(n2), 64'd8);
      chk("t6_count_sat", {62'd0, instr_count2}, 64'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
